// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Purpose: opcode/funct constants used by the control decoder, the hazard
// controller and the forwarding unit, plus the hazard FSM state encoding.
// Contents:
//   R_FORMAT, J, BEQ, ANDI, LW, SW : primary opcodes (6 bits)
//   FUNCT_JR                       : funct field of jr
//   hz_state_t                     : hazard FSM states RUN/JR_WAIT/FLUSH
//   WD_LAST                        : last JR_WAIT watchdog count before a forced exit
//   is_jr()                        : true when opcode/funct decode to jr
package mips_pkg;

    localparam logic [5:0] R_FORMAT = 6'd0;
    localparam logic [5:0] J        = 6'd2;
    localparam logic [5:0] BEQ      = 6'd4;
    localparam logic [5:0] ANDI     = 6'd12;
    localparam logic [5:0] LW       = 6'd35;
    localparam logic [5:0] SW       = 6'd43;
    localparam logic [5:0] FUNCT_JR = 6'd8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        JR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } hz_state_t;

    // The watchdog counts 0,1,2 while in JR_WAIT; a hazard still present on
    // count 2 is the third JR_WAIT cycle, after which RUN is forced.
    localparam logic [1:0] WD_LAST = 2'd2;

    function automatic logic is_jr(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == R_FORMAT) && (funct == FUNCT_JR);
    endfunction

endpackage

// File: rtl/hazard_src_use.sv
// Source-operand usage decoder.
// Purpose: tells whether the instruction in ID actually reads rs and/or rt,
// so hazard and forwarding logic ignore don't-care register fields.
// Ports:
//   opcode : in  6  primary opcode of the instruction
//   use_rs : out 1  instruction reads rs
//   use_rt : out 1  instruction reads rt
// Purely combinational.
module hazard_src_use
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       use_rs,
    output logic       use_rt
);

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (opcode)
            R_FORMAT, SW, BEQ: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            LW, ANDI: begin
                use_rs = 1'b1;
            end
            default: begin
                // J and everything else read no register operands.
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Purpose: detects load-use and jr hazards in ID, requests decoder bubbles,
// freezes PC/IF-ID during stalls and squashes wrong-path work after a
// redirect resolved in MEM. Outputs are combinational (Mealy) from the FSM
// state and the current stage inputs.
// Optional feature: define HAZARD_STATS_EN to add the saturating
// stall_cnt/flush_cnt statistics counters and their ports.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   id_opcode, id_funct          : instruction in ID
//   id_rs, id_rt                 : ID source registers
//   ex_memread, ex_regwrite      : ID/EX control bits
//   ex_dst                       : ID/EX destination register
//   mem_memread, mem_dst         : EX/MEM MemRead and destination
//   mem_redirect                 : taken branch/jump resolved in MEM
//   nop                          : bubble request to the control decoder
//   pc_write, ifid_write         : PC and IF/ID write enables
//   if_flush, idex_flush, exmem_flush : squash the pipeline register
//   stall_cnt, flush_cnt         : statistics (HAZARD_STATS_EN only)
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_redirect,
    output logic             nop,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic             idex_flush,
    output logic             exmem_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    hz_state_t  state_reg;
    logic [1:0] wd_reg;

    logic use_rs;
    logic use_rt;

    hazard_src_use u_src_use (
        .opcode (id_opcode),
        .use_rs (use_rs),
        .use_rt (use_rt)
    );

    // Register 0 is hard-wired, so a read of $0 can never depend on anything.
    logic rs_live;
    logic rt_live;
    assign rs_live = use_rs && (id_rs != '0);
    assign rt_live = use_rt && (id_rt != '0);

    logic load_use;
    assign load_use = ex_memread && (ex_dst != '0) &&
                      ((rs_live && (ex_dst == id_rs)) || (rt_live && (ex_dst == id_rt)));

    // jr resolves its target in ID, so it must wait for an ALU result still
    // in EX or for a load still in MEM (neither is forwardable into ID).
    logic jr_hazard;
    assign jr_hazard = is_jr(id_opcode, id_funct) && (id_rs != '0) &&
                       ((ex_regwrite && (ex_dst == id_rs)) ||
                        (mem_memread && (mem_dst == id_rs)));

    always_comb begin
        nop         = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if_flush    = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            nop         = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            if_flush    = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_redirect) begin
            // Redirect beats any stall; pc_write stays 1 so the target loads.
            if_flush    = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            nop         = (state_reg == FLUSH);
        end else begin
            case (state_reg)
                RUN: begin
                    if (jr_hazard || load_use) begin
                        nop        = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end
                end
                JR_WAIT: begin
                    if (jr_hazard) begin
                        nop        = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end
                end
                FLUSH: begin
                    // Kill the wrong-path fetch that was already in flight.
                    nop      = 1'b1;
                    if_flush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            wd_reg    <= 2'd0;
        end else if (mem_redirect) begin
            state_reg <= FLUSH;
            wd_reg    <= 2'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    wd_reg <= 2'd0;
                    if (jr_hazard) begin
                        state_reg <= JR_WAIT;
                    end
                end
                JR_WAIT: begin
                    if (!jr_hazard || (wd_reg == WD_LAST)) begin
                        state_reg <= RUN;
                        wd_reg    <= 2'd0;
                    end else begin
                        wd_reg <= wd_reg + 2'd1;
                    end
                end
                FLUSH: begin
                    state_reg <= RUN;
                    wd_reg    <= 2'd0;
                end
                default: begin
                    state_reg <= RUN;
                    wd_reg    <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (exmem_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the hazard rules.
// Output vector order: {nop, pc_write, ifid_write, if_flush, idex_flush, exmem_flush}.
module tb_hazard_ctrl;
    import mips_pkg::*;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    localparam logic [5:0] O_RESET   = 6'b100111;
    localparam logic [5:0] O_IDLE    = 6'b011000;
    localparam logic [5:0] O_STALL   = 6'b100000;
    localparam logic [5:0] O_REDIR   = 6'b011111;
    localparam logic [5:0] O_REDIR_F = 6'b111111;
    localparam logic [5:0] O_FLUSH   = 6'b111100;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       id_opcode, id_funct;
    logic [REG_W-1:0] id_rs, id_rt, ex_dst, mem_dst;
    logic             ex_memread, ex_regwrite, mem_memread, mem_redirect;
    logic             nop, pc_write, ifid_write, if_flush, idex_flush, exmem_flush;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_dst       (ex_dst),
        .mem_memread  (mem_memread),
        .mem_dst      (mem_dst),
        .mem_redirect (mem_redirect),
        .nop          (nop),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .if_flush     (if_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    logic [5:0] obs;
    assign obs = {nop, pc_write, ifid_write, if_flush, idex_flush, exmem_flush};

    int n_tests = 0;
    int n_fail  = 0;

    // One pipeline cycle: apply inputs just after the edge, sample at the falling edge.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic exmr, input logic exrw, input logic [4:0] exd,
                       input logic memr, input logic [4:0] memd, input logic redir);
        @(posedge clk);
        #1;
        rst = r; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt;
        ex_memread = exmr; ex_regwrite = exrw; ex_dst = exd;
        mem_memread = memr; mem_dst = memd; mem_redirect = redir;
        @(negedge clk);
        $display("[TB] t=%0t rst=%b op=%0d fn=%0d rs=%0d rt=%0d ex(mr=%b rw=%b d=%0d) mem(mr=%b d=%0d) redir=%b -> out=%b",
                 $time, r, op, fn, rs, rt, exmr, exrw, exd, memr, memd, redir, obs);
    endtask

    task automatic idle_cyc();
        cyc(0, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(1, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (obs !== O_RESET) begin n_fail++; $display("FAIL reset_out: got %b want %b", obs, O_RESET); end
        idle_cyc();
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, O_IDLE); end
`ifdef HAZARD_STATS_EN
        n_tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
    endtask

    task automatic test_load_use();
        // lw $2 in EX, add using $2 in ID
        cyc(0, R_FORMAT, 6'd32, 2, 3, 1, 1, 2, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL lu_stall: got %b want %b", obs, O_STALL); end
        cyc(0, R_FORMAT, 6'd32, 2, 3, 0, 0, 0, 0, 0, 0);
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL lu_release: got %b want %b", obs, O_IDLE); end
        // lw $0 never stalls
        cyc(0, R_FORMAT, 6'd32, 0, 3, 1, 1, 0, 0, 0, 0);
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL lu_reg0: got %b want %b", obs, O_IDLE); end
        // sw reads rt
        cyc(0, SW, 6'd0, 1, 4, 1, 1, 4, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL lu_sw_rt: got %b want %b", obs, O_STALL); end
        // andi does not read rt
        cyc(0, ANDI, 6'd0, 1, 4, 1, 1, 4, 0, 0, 0);
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL lu_andi_rt: got %b want %b", obs, O_IDLE); end
        // j reads nothing
        cyc(0, J, 6'd0, 4, 4, 1, 1, 4, 0, 0, 0);
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL lu_j: got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_jr();
        cyc(0, R_FORMAT, FUNCT_JR, 5, 0, 0, 1, 5, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL jr_ex: got %b want %b", obs, O_STALL); end
        cyc(0, R_FORMAT, FUNCT_JR, 5, 0, 0, 0, 0, 1, 5, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL jr_mem: got %b want %b", obs, O_STALL); end
        cyc(0, R_FORMAT, FUNCT_JR, 5, 0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL jr_done: got %b want %b", obs, O_IDLE); end
        // Back in RUN: a load-use on rt of an R-type stalls again.
        cyc(0, R_FORMAT, 6'd32, 0, 6, 1, 1, 6, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL jr_then_run: got %b want %b", obs, O_STALL); end
    endtask

    task automatic test_redirect();
        cyc(0, R_FORMAT, 6'd32, 2, 3, 1, 1, 2, 0, 0, 1);
        n_tests++; if (obs !== O_REDIR) begin n_fail++; $display("FAIL redir_over_stall: got %b want %b", obs, O_REDIR); end
        cyc(0, R_FORMAT, 6'd32, 2, 3, 1, 1, 2, 0, 0, 0);
        n_tests++; if (obs !== O_FLUSH) begin n_fail++; $display("FAIL redir_flush: got %b want %b", obs, O_FLUSH); end
        idle_cyc();
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL redir_idle: got %b want %b", obs, O_IDLE); end
        // back-to-back redirects
        cyc(0, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (obs !== O_REDIR) begin n_fail++; $display("FAIL b2b_first: got %b want %b", obs, O_REDIR); end
        cyc(0, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (obs !== O_REDIR_F) begin n_fail++; $display("FAIL b2b_in_flush: got %b want %b", obs, O_REDIR_F); end
        idle_cyc();
        n_tests++; if (obs !== O_FLUSH) begin n_fail++; $display("FAIL b2b_flush: got %b want %b", obs, O_FLUSH); end
        // redirect overrides JR_WAIT
        cyc(0, R_FORMAT, FUNCT_JR, 7, 0, 0, 1, 7, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL jrw_enter: got %b want %b", obs, O_STALL); end
        cyc(0, R_FORMAT, FUNCT_JR, 7, 0, 0, 0, 0, 1, 7, 1);
        n_tests++; if (obs !== O_REDIR) begin n_fail++; $display("FAIL jrw_redir: got %b want %b", obs, O_REDIR); end
        cyc(0, R_FORMAT, FUNCT_JR, 7, 0, 0, 0, 0, 1, 7, 0);
        n_tests++; if (obs !== O_FLUSH) begin n_fail++; $display("FAIL jrw_flush: got %b want %b", obs, O_FLUSH); end
        idle_cyc();
    endtask

    task automatic test_reset_mid_stall();
        // jr $5 with rt=3 and a load of $3 in EX: load-use on rt only matters in RUN.
        cyc(0, R_FORMAT, FUNCT_JR, 5, 3, 0, 1, 5, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL rst_jr_enter: got %b want %b", obs, O_STALL); end
        cyc(1, R_FORMAT, FUNCT_JR, 5, 3, 0, 1, 5, 0, 0, 0);
        n_tests++; if (obs !== O_RESET) begin n_fail++; $display("FAIL rst_in_jrwait: got %b want %b", obs, O_RESET); end
        cyc(0, R_FORMAT, FUNCT_JR, 5, 3, 1, 1, 3, 0, 0, 0);
        n_tests++; if (obs !== O_STALL) begin n_fail++; $display("FAIL rst_state_run: got %b want %b", obs, O_STALL); end
`ifdef HAZARD_STATS_EN
        n_tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
`endif
        // reset during FLUSH
        cyc(0, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (obs !== O_RESET) begin n_fail++; $display("FAIL rst_in_flush: got %b want %b", obs, O_RESET); end
        idle_cyc();
        n_tests++; if (obs !== O_IDLE) begin n_fail++; $display("FAIL rst_flush_abort: got %b want %b", obs, O_IDLE); end
    endtask

    // ---------------- reference model ----------------
    bit m_flush_pending;   // previous cycle took a redirect
    int m_jr_cycles;       // 0: not holding a jr; k: k-th cycle holding it
    int m_stall, m_flush;  // expected statistics

    function automatic logic m_reads_rs(input logic [5:0] op);
        return op inside {R_FORMAT, LW, SW, BEQ, ANDI};
    endfunction

    function automatic logic m_reads_rt(input logic [5:0] op);
        return op inside {R_FORMAT, SW, BEQ};
    endfunction

    task automatic model_step(output logic [5:0] e);
        logic lu, jh;
        lu = ex_memread && ex_dst != 0 &&
             ((m_reads_rs(id_opcode) && ex_dst == id_rs) || (m_reads_rt(id_opcode) && ex_dst == id_rt));
        jh = id_opcode == 0 && id_funct == 8 && id_rs != 0 &&
             ((ex_regwrite && ex_dst == id_rs) || (mem_memread && mem_dst == id_rs));
        e = O_IDLE;
        if (rst) begin
            e = O_RESET; m_flush_pending = 0; m_jr_cycles = 0;
        end else if (mem_redirect) begin
            e = m_flush_pending ? O_REDIR_F : O_REDIR;
            m_flush_pending = 1; m_jr_cycles = 0;
        end else if (m_flush_pending) begin
            e = O_FLUSH; m_flush_pending = 0;
        end else if (m_jr_cycles > 0) begin
            if (jh) begin
                e = O_STALL;
                m_jr_cycles = (m_jr_cycles >= 3) ? 0 : m_jr_cycles + 1;
            end else begin
                m_jr_cycles = 0;
            end
        end else if (jh) begin
            e = O_STALL; m_jr_cycles = 1;
        end else if (lu) begin
            e = O_STALL;
        end
    endtask

    task automatic test_random();
        logic [5:0] op_tab [8];
        logic [5:0] e;
        op_tab = '{R_FORMAT, R_FORMAT, J, BEQ, ANDI, LW, SW, 6'd8};
        cyc(1, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(e);
        m_stall = 0; m_flush = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 39) == 0),
                op_tab[$urandom_range(0, 7)],
                ($urandom_range(0, 1) == 1) ? FUNCT_JR : 6'($urandom_range(0, 63)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0));
`ifdef HAZARD_STATS_EN
            n_tests++; if (stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
`endif
            model_step(e);
            n_tests++; if (obs !== e) begin n_fail++; $display("FAIL rand_out[%0d]: got %b want %b", i, obs, e); end
            if (rst) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (e[4] == 1'b0 && m_stall < 15) m_stall++;
                if (e[0] == 1'b1 && m_flush < 15) m_flush++;
            end
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats_saturate();
        cyc(1, R_FORMAT, 6'd32, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, R_FORMAT, 6'd32, 2, 3, 1, 1, 2, 0, 0, 0);
            if (i == 6) begin
                n_tests++; if (stall_cnt !== 4'd6) begin n_fail++; $display("FAIL stats_mid: got %0d want 6", stall_cnt); end
            end
        end
        idle_cyc();
        n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stats_sat: got %0d want 15", stall_cnt); end
        n_tests++; if (flush_cnt !== 4'd0) begin n_fail++; $display("FAIL stats_flush0: got %0d want 0", flush_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; id_opcode = '0; id_funct = '0; id_rs = '0; id_rt = '0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst = '0;
        mem_memread = 1'b0; mem_dst = '0; mem_redirect = 1'b0;
        m_flush_pending = 0; m_jr_cycles = 0; m_stall = 0; m_flush = 0;
        test_reset();
        test_load_use();
        test_jr();
        test_redirect();
        test_reset_mid_stall();
        test_random();
`ifdef HAZARD_STATS_EN
        test_stats_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
